// File: rtl/data_sram_resp_if.sv
// ============================================================================
// data_sram_resp_if : CPU data-SRAM request/response bundle (EX/MEM side).
// Rev 1.0
// ============================================================================
`default_nettype none

interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq, err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq, err
  );
endinterface

`default_nettype wire

// File: rtl/data_sram_resp.sv
// ============================================================================
// data_sram_resp : byte-writable word SRAM responder with WAIT_CYCLES stalls.
// Optional feature macro: DSRAM_RANGE_CHECK_EN (out-of-range detection).
// Rev 1.0
// ============================================================================
`default_nettype none

module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  data_sram_resp_if.slave   bus
);

  localparam int         c_DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [31:0]       mem_q [c_DEPTH];

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              oor_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;
  logic              stallreq_q;
  logic              err_q;
  logic              err_d;

  logic [ADDR_W-1:0] w_req_idx;
  logic              w_req_oor;
  logic              w_cmt_vld;
  logic [3:0]        w_cmt_wen;
  logic [ADDR_W-1:0] w_cmt_idx;
  logic [31:0]       w_cmt_wdata;
  logic              w_cmt_oor;
  logic              w_unused_sig;

  assign w_req_idx = bus.data_sram_addr[ADDR_W+1:2];

`ifdef DSRAM_RANGE_CHECK_EN
  assign w_req_oor    = |bus.data_sram_addr[31:ADDR_W+2];
  assign w_unused_sig = ^bus.data_sram_addr[1:0];
  assign bus.err      = err_q;
`else
  assign w_req_oor    = 1'b0;
  assign w_unused_sig = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0], err_q};
  assign bus.err      = 1'b0;
`endif

  // With no wait states the live request commits at the accept edge;
  // otherwise the latched copy commits on the last wait edge.
  always_comb begin
    w_cmt_vld   = 1'b0;
    w_cmt_wen   = wen_q;
    w_cmt_idx   = idx_q;
    w_cmt_wdata = wdata_q;
    w_cmt_oor   = oor_q;
    if (WAIT_CYCLES == 0) begin
      w_cmt_vld   = resetn && (state_q == S_IDLE) && bus.data_sram_en;
      w_cmt_wen   = bus.data_sram_wen;
      w_cmt_idx   = w_req_idx;
      w_cmt_wdata = bus.data_sram_wdata;
      w_cmt_oor   = w_req_oor;
    end else begin
      w_cmt_vld   = resetn && (state_q == S_WAIT) && (cnt_q == 4'd1);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = w_cmt_vld && w_cmt_oor;
    if (w_cmt_vld && (w_cmt_wen == 4'd0)) begin
      rdata_d = w_cmt_oor ? 32'h0000_0000 : mem_q[w_cmt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (w_cmt_vld && !w_cmt_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_cmt_wen[i]) begin
          mem_q[w_cmt_idx][8*i +: 8] <= w_cmt_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wen_q      <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      oor_q      <= 1'b0;
      rdata_q    <= 32'd0;
      stallreq_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
      case (state_q)
        S_IDLE: begin
          if (bus.data_sram_en && (WAIT_CYCLES != 0)) begin
            wen_q      <= bus.data_sram_wen;
            idx_q      <= w_req_idx;
            wdata_q    <= bus.data_sram_wdata;
            oor_q      <= w_req_oor;
            cnt_q      <= c_WAIT;
            stallreq_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            stallreq_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          stallreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign bus.stallreq        = stallreq_q;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_resp.sv
// ============================================================================
// tb_data_sram_resp : three responders (0/3/2 wait states) against a word-array model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a  [3];
  logic        en_a    [3];
  logic [3:0]  wen_a   [3];
  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rd_a    [3];
  logic        st_a    [3];
  logic        err_a   [3];

  data_sram_resp_if bus0 ();
  data_sram_resp_if bus1 ();
  data_sram_resp_if bus2 ();

  assign bus0.data_sram_en = en_a[0];  assign bus0.data_sram_wen = wen_a[0];
  assign bus0.data_sram_addr = addr_a[0]; assign bus0.data_sram_wdata = wdata_a[0];
  assign bus1.data_sram_en = en_a[1];  assign bus1.data_sram_wen = wen_a[1];
  assign bus1.data_sram_addr = addr_a[1]; assign bus1.data_sram_wdata = wdata_a[1];
  assign bus2.data_sram_en = en_a[2];  assign bus2.data_sram_wen = wen_a[2];
  assign bus2.data_sram_addr = addr_a[2]; assign bus2.data_sram_wdata = wdata_a[2];
  assign rd_a[0] = bus0.data_sram_rdata; assign st_a[0] = bus0.stallreq; assign err_a[0] = bus0.err;
  assign rd_a[1] = bus1.data_sram_rdata; assign st_a[1] = bus1.stallreq; assign err_a[1] = bus1.err;
  assign rd_a[2] = bus2.data_sram_rdata; assign st_a[2] = bus2.stallreq; assign err_a[2] = bus2.err;

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .resetn(rstn_a[0]), .bus(bus0));
  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .resetn(rstn_a[1]), .bus(bus1));
  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .resetn(rstn_a[2]), .bus(bus2));

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl_mem [3][1024];
  logic [31:0] mdl_rd  [3];

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Reference: a word array updated per whole access; upper address bits either wrap or flag.
  task automatic mdl_step(input int k, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    logic oor;
    idx = int'(addr[11:2]);
`ifdef DSRAM_RANGE_CHECK_EN
    oor = (addr[31:12] != 20'd0);
`else
    oor = 1'b0;
`endif
    exp_err = oor;
    exp_rd  = mdl_rd[k];
    if (wen == 4'd0) begin
      exp_rd = oor ? 32'd0 : mdl_mem[k][idx];
    end else if (!oor) begin
      for (int b = 0; b < 4; b++)
        if (wen[b]) mdl_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  // Starts and ends on a falling edge; scrambles the inputs while stalled.
  task automatic access(input int k, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag);
    en_a[k] = 1'b1; wen_a[k] = wen; addr_a[k] = addr; wdata_a[k] = wdata;
    @(posedge clk);
    for (int c = 0; c < wait_of(k); c++) begin
      @(negedge clk);
      chk({tag, "_stall_hi"}, 32'(st_a[k]), 32'd1);
      chk({tag, "_rd_hold"}, rd_a[k], mdl_rd[k]);
      chk({tag, "_err_lo"}, 32'(err_a[k]), 32'd0);
      addr_a[k] = $urandom; wdata_a[k] = $urandom; wen_a[k] = 4'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "_stall_lo"}, 32'(st_a[k]), 32'd0);
    chk({tag, "_rdata"}, rd_a[k], exp_rd);
    chk({tag, "_err"}, 32'(err_a[k]), 32'(exp_err));
    mdl_rd[k] = exp_rd;
    en_a[k] = 1'b0; wen_a[k] = 4'd0;
  endtask

  task automatic macc(input int k, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    logic [31:0] e_rd;
    logic        e_err;
    mdl_step(k, wen, addr, wdata, e_rd, e_err);
    access(k, wen, addr, wdata, e_rd, e_err, tag);
  endtask

  typedef struct {
    int          k;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] e_rd;
    logic        e_err;

    vecs[0] = '{0, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{0, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{0, 4'hF, 32'h20, 32'h11223344, 32'hDEADBEEF};
    vecs[3] = '{0, 4'h4, 32'h20, 32'h00AA0000, 32'hDEADBEEF};
    vecs[4] = '{0, 4'h0, 32'h20, 32'h0,        32'h11AA3344};
    vecs[5] = '{0, 4'hF, 32'h40, 32'hCAFEF00D, 32'h11AA3344};
    vecs[6] = '{0, 4'h0, 32'h40, 32'h0,        32'hCAFEF00D};
    vecs[7] = '{1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0};
    vecs[8] = '{1, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF};

    for (int k = 0; k < 3; k++) begin
      rstn_a[k] = 1'b0; en_a[k] = 1'b0; wen_a[k] = 4'd0; addr_a[k] = 32'd0; wdata_a[k] = 32'd0;
      mdl_rd[k] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_rdata", k), rd_a[k], 32'd0);
      chk($sformatf("rst%0d_stall", k), 32'(st_a[k]), 32'd0);
      chk($sformatf("rst%0d_err", k), 32'(err_a[k]), 32'd0);
      rstn_a[k] = 1'b1;
    end
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mdl_step(vecs[i].k, vecs[i].wen, vecs[i].addr, vecs[i].wdata, e_rd, e_err);
      access(vecs[i].k, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Reset during the wait of a write: the write must be dropped.
    macc(2, 4'hF, 32'h30, 32'h12345678, "pre30");
    macc(2, 4'h0, 32'h30, 32'h0, "rd30a");
    en_a[2] = 1'b1; wen_a[2] = 4'hF; addr_a[2] = 32'h30; wdata_a[2] = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    chk("rstwait_stall_hi", 32'(st_a[2]), 32'd1);
    rstn_a[2] = 1'b0;
    #1;
    chk("rstwait_stall", 32'(st_a[2]), 32'd0);
    chk("rstwait_rdata", rd_a[2], 32'd0);
    en_a[2] = 1'b0; wen_a[2] = 4'd0;
    mdl_rd[2] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rstn_a[2] = 1'b1;
    @(negedge clk);
    macc(2, 4'h0, 32'h30, 32'h0, "rd30b");
    chk("rd30b_old", rd_a[2], 32'h12345678);

    // Upper address bits: wrap without the range check, flag with it.
    macc(0, 4'hF, 32'h0, 32'hA5A50000, "pre0");
    macc(0, 4'h0, 32'h0001_0000, 32'h0, "rd_hi");
    macc(0, 4'hF, 32'h0001_0000, 32'h0BADBEEF, "wr_hi");
    macc(0, 4'h0, 32'h0, 32'h0, "rd0");
    @(posedge clk); @(negedge clk);
    chk("err_pulse_end", 32'(err_a[0]), 32'd0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++)
        macc(k, 4'hF, 32'h200 + 32'(4 * i), $urandom, $sformatf("pool%0d_%0d", k, i));
      for (int n = 0; n < 30; n++) begin
        logic [31:0] a;
        logic [3:0]  w;
        a = 32'h200 + 32'(4 * $urandom_range(0, 7));
        a[1:0] = 2'($urandom);
        if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 1048575));
        w = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        macc(k, w, a, $urandom, $sformatf("rnd%0d_%0d", k, n));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); @(negedge clk);
          chk($sformatf("idle%0d_%0d_rd", k, n), rd_a[k], mdl_rd[k]);
          chk($sformatf("idle%0d_%0d_st", k, n), 32'(st_a[k]), 32'd0);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
